// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - single-clock parametrised FIFO with almost flags, sticky errors, flush and FWFT
module sync_fifo_param #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int FWFT       = 0,
    parameter int AF_THRESH  = 14,
    parameter int AE_THRESH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int                DEPTH   = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AE_THRESH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  full_q, empty_q, almost_full_q, almost_empty_q;
    logic                  overflow_q, underflow_q;
    logic                  wr_acc, rd_acc;
    logic                  flush;

    // Acceptance uses registered full/empty only, so a same-cycle read never frees room for a write
    always_comb begin
        flush    = rst | clr;
        wr_acc   = wr_en & ~full_q;
        rd_acc   = rd_en & ~empty_q;
        wr_ptr_d = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = rd_acc ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer, occupancy, flag and sticky-error state; flags are derived from the next occupancy
    always_ff @(posedge clk) begin
        if (flush) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            full_q         <= 1'b0;
            empty_q        <= 1'b1;
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            full_q         <= (count_d == DEPTH_C);
            empty_q        <= (count_d == '0);
            almost_full_q  <= (count_d >= AF_C);
            almost_empty_q <= (count_d <= AE_C);
            if (wr_en && full_q)
                overflow_q <= 1'b1;
            if (rd_en && empty_q)
                underflow_q <= 1'b1;
        end
    end

    // Storage array: no reset so it maps onto block/distributed RAM
    always_ff @(posedge clk) begin
        if (!flush && wr_acc)
            mem_q[wr_ptr_q] <= wr_data;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head of queue is presented directly; zero while nothing is stored
            always_comb begin
                rd_data  = empty_q ? '0 : mem_q[rd_ptr_q];
                rd_valid = ~empty_q;
            end
        end else begin : g_std
            logic [DATA_WIDTH-1:0] rd_data_q;
            logic                  rd_valid_q;

            // Registered read: data appears the cycle after the accepted read and then holds
            always_ff @(posedge clk) begin
                if (flush) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= rd_acc;
                    if (rd_acc)
                        rd_data_q <= mem_q[rd_ptr_q];
                end
            end

            assign rd_data  = rd_data_q;
            assign rd_valid = rd_valid_q;
        end
    endgenerate

    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = almost_full_q;
    assign almost_empty = almost_empty_q;
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - directed self-checking bench for sync_fifo_param (standard and FWFT instances)
module tb_sync_fifo_param;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    // standard-read instance
    logic       clr = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic [7:0] rd_data;
    logic       rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
    logic [4:0] count;

    // FWFT instance
    logic       f_clr = 1'b0, f_wr_en = 1'b0, f_rd_en = 1'b0;
    logic [7:0] f_wr_data = 8'h00;
    logic [7:0] f_rd_data;
    logic       f_rd_valid, f_full, f_empty, f_almost_full, f_almost_empty, f_overflow, f_underflow;
    logic [4:0] f_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sync_fifo_param #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(0), .AF_THRESH(14), .AE_THRESH(2)) u_dut (
        .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    sync_fifo_param #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(1), .AF_THRESH(14), .AE_THRESH(2)) u_fwft (
        .clk(clk), .rst(rst), .clr(f_clr), .wr_en(f_wr_en), .wr_data(f_wr_data), .rd_en(f_rd_en),
        .rd_data(f_rd_data), .rd_valid(f_rd_valid), .full(f_full), .empty(f_empty),
        .almost_full(f_almost_full), .almost_empty(f_almost_empty), .count(f_count),
        .overflow(f_overflow), .underflow(f_underflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // advance one clock edge and settle away from it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // 1. reset
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("rst_empty",     32'(empty), 32'd1);
        check("rst_aempty",    32'(almost_empty), 32'd1);
        check("rst_full",      32'(full), 32'd0);
        check("rst_afull",     32'(almost_full), 32'd0);
        check("rst_count",     32'(count), 32'd0);
        check("rst_rd_valid",  32'(rd_valid), 32'd0);
        check("rst_rd_data",   32'(rd_data), 32'h00);
        check("rst_overflow",  32'(overflow), 32'd0);
        check("rst_underflow", 32'(underflow), 32'd0);
        check("rst_f_rd_valid", 32'(f_rd_valid), 32'd0);
        check("rst_f_rd_data", 32'(f_rd_data), 32'h00);

        // 2. fill with 0x00..0x0F, then one write too many
        for (int i = 0; i < 16; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'(i);
            step();
            check("fill_count",  32'(count), 32'(i + 1));
            check("fill_aempty", 32'(almost_empty), (i + 1 <= 2) ? 32'd1 : 32'd0);
            check("fill_afull",  32'(almost_full), (i + 1 >= 14) ? 32'd1 : 32'd0);
            check("fill_full",   32'(full), (i + 1 == 16) ? 32'd1 : 32'd0);
        end
        wr_data = 8'hAA;
        step();
        wr_en = 1'b0;
        check("ovf_count", 32'(count), 32'd16);
        check("ovf_flag",  32'(overflow), 32'd1);

        // 3. drain 16 words, then a read on empty
        for (int i = 0; i < 16; i++) begin
            rd_en = 1'b1;
            step();
            check("drain_data",  32'(rd_data), 32'(i));
            check("drain_valid", 32'(rd_valid), 32'd1);
            check("drain_count", 32'(count), 32'(15 - i));
        end
        check("drain_empty", 32'(empty), 32'd1);
        step();
        rd_en = 1'b0;
        check("unf_flag",  32'(underflow), 32'd1);
        check("unf_valid", 32'(rd_valid), 32'd0);
        check("unf_hold",  32'(rd_data), 32'h0F);
        check("unf_ovf_sticky", 32'(overflow), 32'd1);
        step();
        check("idle_hold", 32'(rd_data), 32'h0F);

        // flush clears sticky errors
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("clr_ovf",   32'(overflow), 32'd0);
        check("clr_unf",   32'(underflow), 32'd0);
        check("clr_data",  32'(rd_data), 32'h00);
        check("clr_empty", 32'(empty), 32'd1);

        // 4. preload 5, then 40 cycles of simultaneous read+write
        for (int i = 0; i < 5; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'(8'h80 + i);
            step();
        end
        check("pre_count", 32'(count), 32'd5);
        for (int c = 0; c < 40; c++) begin
            wr_en   = 1'b1;
            rd_en   = 1'b1;
            wr_data = 8'(8'h85 + c);
            step();
            check("rw_data",  32'(rd_data), 32'(8'h80 + c));
            check("rw_valid", 32'(rd_valid), 32'd1);
            check("rw_count", 32'(count), 32'd5);
            check("rw_fe",    32'({full, empty}), 32'd0);
        end
        wr_en = 1'b0;
        rd_en = 1'b0;

        // 5a. full boundary: read+write at full drops the write
        clr = 1'b1;
        step();
        clr = 1'b0;
        for (int i = 0; i < 16; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'(8'h10 + i);
            step();
        end
        check("bf_full", 32'(full), 32'd1);
        wr_data = 8'h77;
        rd_en   = 1'b1;
        step();
        wr_en = 1'b0;
        check("bf_count", 32'(count), 32'd15);
        check("bf_ovf",   32'(overflow), 32'd1);
        check("bf_data",  32'(rd_data), 32'h10);
        for (int i = 1; i < 16; i++) begin
            step();
            check("bf_drain", 32'(rd_data), 32'(8'h10 + i));
        end
        rd_en = 1'b0;
        check("bf_empty", 32'(empty), 32'd1);
        check("bf_unf",   32'(underflow), 32'd0);

        // 5b. empty boundary: read+write at empty drops the read
        wr_en   = 1'b1;
        rd_en   = 1'b1;
        wr_data = 8'h33;
        step();
        wr_en = 1'b0;
        check("be_count", 32'(count), 32'd1);
        check("be_unf",   32'(underflow), 32'd1);
        check("be_valid", 32'(rd_valid), 32'd0);
        step();
        rd_en = 1'b0;
        check("be_data",  32'(rd_data), 32'h33);
        check("be_valid2", 32'(rd_valid), 32'd1);
        check("be_count0", 32'(count), 32'd0);

        // 6. FWFT behaviour
        f_wr_en   = 1'b1;
        f_wr_data = 8'h5A;
        step();
        f_wr_en = 1'b0;
        check("fw_valid", 32'(f_rd_valid), 32'd1);
        check("fw_data",  32'(f_rd_data), 32'h5A);
        step();
        check("fw_hold",  32'(f_rd_data), 32'h5A);
        f_rd_en = 1'b1;
        step();
        f_rd_en = 1'b0;
        check("fw_pop_empty", 32'(f_empty), 32'd1);
        check("fw_pop_data",  32'(f_rd_data), 32'h00);
        check("fw_pop_valid", 32'(f_rd_valid), 32'd0);
        for (int i = 0; i < 7; i++) begin
            f_wr_en   = 1'b1;
            f_wr_data = 8'(8'h60 + i);
            step();
        end
        f_wr_en = 1'b0;
        check("fw_cnt7",  32'(f_count), 32'd7);
        check("fw_head",  32'(f_rd_data), 32'h60);
        f_clr = 1'b1;
        step();
        f_clr = 1'b0;
        check("fw_clr_count", 32'(f_count), 32'd0);
        check("fw_clr_empty", 32'(f_empty), 32'd1);
        check("fw_clr_valid", 32'(f_rd_valid), 32'd0);
        f_wr_en   = 1'b1;
        f_wr_data = 8'hC3;
        step();
        f_wr_data = 8'hC4;
        step();
        f_wr_en = 1'b0;
        check("fw_after_clr", 32'(f_rd_data), 32'hC3);
        f_rd_en = 1'b1;
        step();
        f_rd_en = 1'b0;
        check("fw_next",  32'(f_rd_data), 32'hC4);
        check("fw_count", 32'(f_count), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
